// File: rtl/display_scan_ctrl.sv
// Multiplexed 4-digit display scanner with dead-time blanking and frame-synchronous value update.
// Optional leading-zero suppression is enabled by defining DISPLAY_LZ_BLANK_EN.
module display_scan_ctrl #(
  parameter int unsigned CLK_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] value,
  input  logic        load,
  output logic [3:0]  digit_bin,
  output logic [3:0]  an,
  output logic        pending,
  output logic        frame_done
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned DIG_W = 4;
  localparam int unsigned VAL_W = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(3);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [IDX_W-1:0] idx, idx_d;
  logic [CNT_W-1:0] cnt, cnt_d;

  logic [VAL_W-1:0] shadow;
  logic [VAL_W-1:0] active;

  logic [DIG_W-1:0] an_d;
  logic [DIG_W-1:0] digit_bin_d;
  logic             frame_done_d;
  logic [DIG_W-1:0] lz_mask_c;

  logic boundary_c;
  logic commit_c;

  // Frame boundary is the last SHOW cycle of digit 3 while scanning continues.
  assign boundary_c = en && (state == SHOW) && (idx == IDX_LAST) && (cnt == CNT_LAST);
  // Commit either at a frame boundary or while dark in IDLE, so no frame mixes values.
  assign commit_c   = pending && (boundary_c || (state == IDLE));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
      cnt   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    idx_d   = idx;
    cnt_d   = cnt;
    if (!en) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          state_d = BLANK;
          idx_d   = '0;
          cnt_d   = '0;
        end
        BLANK: begin
          state_d = SHOW;
          cnt_d   = '0;
        end
        SHOW: begin
          if (cnt == CNT_LAST) begin
            state_d = BLANK;
            idx_d   = idx + IDX_W'(1);
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Leading-zero mask: digit k goes dark when nibbles k..3 of the active value are all zero
`ifdef DISPLAY_LZ_BLANK_EN
  always_comb begin
    lz_mask_c    = '0;
    lz_mask_c[3] = (active[15:12] == 4'h0);
    lz_mask_c[2] = (active[15:8]  == 8'h00);
    lz_mask_c[1] = (active[15:4]  == 12'h000);
  end
`else
  always_comb begin
    lz_mask_c = '0;
  end
`endif

  // Output logic: values for the cycle the FSM is about to enter
  always_comb begin
    an_d         = 4'b1111;
    digit_bin_d  = digit_bin;
    frame_done_d = boundary_c;
    if (state_d == SHOW) begin
      an_d        = DIG_W'(~(4'b0001 << idx_d)) | lz_mask_c;
      digit_bin_d = active[{idx_d, 2'b00} +: DIG_W];
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      an         <= 4'b1111;
      digit_bin  <= '0;
      frame_done <= 1'b0;
    end else begin
      an         <= an_d;
      digit_bin  <= digit_bin_d;
      frame_done <= frame_done_d;
    end
  end

  // Shadow/active double buffer; a load on a commit cycle lands in shadow and stays pending
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow  <= '0;
      active  <= '0;
      pending <= 1'b0;
    end else begin
      if (load) begin
        shadow <= value;
      end
      if (commit_c) begin
        active <= shadow;
      end
      if (load) begin
        pending <= 1'b1;
      end else if (commit_c) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with CLK_DIV=4 (5-cycle digits, 20-cycle frames).
module tb_display_scan_ctrl;

  localparam int unsigned CLK_DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  digit_bin;
  logic [3:0]  an;
  logic        pending;
  logic        frame_done;

  int errors = 0;
  int checks = 0;
  int ph = -1;

  display_scan_ctrl #(.CLK_DIV(CLK_DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .value      (value),
    .load       (load),
    .digit_bin  (digit_bin),
    .an         (an),
    .pending    (pending),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle; ph counts cycles since en was raised (0 = first BLANK).
  task automatic tick();
    @(posedge clk);
    #1;
    ph++;
  endtask

  task automatic go_until(input int n);
    while (ph < n) tick();
  endtask

  // Expected anode pattern for a given scan cycle, all digits lit.
  function automatic logic [3:0] an_model(input int i);
    int p;
    p = i % 20;
    if (p % 5 == 0) return 4'hF;
    return 4'(~(4'b0001 << (p / 5)));
  endfunction

  task automatic restart();
    rst = 1'b1; en = 1'b0; load = 1'b0;
    tick();
    rst = 1'b0; en = 1'b1; ph = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; load = 1'b1; value = 16'hFFFF;
    tick();
    tick();
    load = 1'b0;
    checks++; if (an !== 4'hF) begin errors++; $display("FAIL reset_an: got %b want 1111", an); end
    checks++; if (digit_bin !== 4'h0) begin errors++; $display("FAIL reset_digit: got %h want 0", digit_bin); end
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b want 0", pending); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
  endtask

  task automatic test_scan();
    logic exp_fd;
    restart();
    repeat (41) begin
      tick();
      exp_fd = (ph % 20 == 0) && (ph > 0);
      checks++; if (an !== an_model(ph)) begin errors++; $display("FAIL scan_an[%0d]: got %b want %b", ph, an, an_model(ph)); end
      checks++; if (frame_done !== exp_fd) begin errors++; $display("FAIL scan_frame_done[%0d]: got %b want %b", ph, frame_done, exp_fd); end
    end
    checks++; if (digit_bin !== 4'h0) begin errors++; $display("FAIL scan_digit: got %h want 0", digit_bin); end
  endtask

  task automatic test_load();
    restart();
    go_until(6);
    load = 1'b1; value = 16'h1A3F;
    tick();
    load = 1'b0;
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL load_pending: got %b want 1", pending); end
    checks++; if (an !== 4'b1101) begin errors++; $display("FAIL load_an: got %b want 1101", an); end
    checks++; if (digit_bin !== 4'h0) begin errors++; $display("FAIL load_no_tear: got %h want 0", digit_bin); end
    go_until(19);
    checks++; if (digit_bin !== 4'h0) begin errors++; $display("FAIL load_old_d3: got %h want 0", digit_bin); end
    tick();
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL load_commit: got %b want 0", pending); end
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL load_frame_done: got %b want 1", frame_done); end
    checks++; if (digit_bin !== 4'h0) begin errors++; $display("FAIL load_blank_hold: got %h want 0", digit_bin); end
    tick();
    checks++; if (digit_bin !== 4'hF) begin errors++; $display("FAIL load_d0: got %h want F", digit_bin); end
    go_until(26);
    checks++; if (digit_bin !== 4'h3) begin errors++; $display("FAIL load_d1: got %h want 3", digit_bin); end
    go_until(31);
    checks++; if (digit_bin !== 4'hA) begin errors++; $display("FAIL load_d2: got %h want A", digit_bin); end
    go_until(36);
    checks++; if (digit_bin !== 4'h1) begin errors++; $display("FAIL load_d3: got %h want 1", digit_bin); end
    checks++; if (an !== 4'b0111) begin errors++; $display("FAIL load_d3_an: got %b want 0111", an); end
  endtask

  task automatic test_back_to_back();
    restart();
    go_until(2);
    load = 1'b1; value = 16'h1111;
    tick();
    load = 1'b0;
    go_until(10);
    load = 1'b1; value = 16'h2222;
    tick();
    load = 1'b0;
    go_until(19);
    load = 1'b1; value = 16'h3333;
    tick();
    load = 1'b0;
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL b2b_frame_done: got %b want 1", frame_done); end
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL b2b_pending: got %b want 1", pending); end
    tick();
    checks++; if (digit_bin !== 4'h2) begin errors++; $display("FAIL b2b_d0: got %h want 2", digit_bin); end
    go_until(36);
    checks++; if (digit_bin !== 4'h2) begin errors++; $display("FAIL b2b_d3: got %h want 2", digit_bin); end
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL b2b_pending_hold: got %b want 1", pending); end
    go_until(40);
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL b2b_commit2: got %b want 0", pending); end
    tick();
    checks++; if (digit_bin !== 4'h3) begin errors++; $display("FAIL b2b_next_d0: got %h want 3", digit_bin); end
  endtask

  // Load while dark in IDLE; leaves en low with v committed to active.
  task automatic test_idle_commit(input logic [15:0] v);
    rst = 1'b1; en = 1'b0; load = 1'b0;
    tick();
    rst = 1'b0; load = 1'b1; value = v;
    tick();
    load = 1'b0;
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL idle_load_pending: got %b want 1", pending); end
    tick();
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL idle_commit_pending: got %b want 0", pending); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL idle_frame_done: got %b want 0", frame_done); end
    checks++; if (an !== 4'hF) begin errors++; $display("FAIL idle_an: got %b want 1111", an); end
  endtask

  task automatic test_en_drop();
    test_idle_commit(16'h4321);
    en = 1'b1; ph = -1;
    go_until(12);
    checks++; if (an !== 4'b1011) begin errors++; $display("FAIL endrop_an_d2: got %b want 1011", an); end
    checks++; if (digit_bin !== 4'h3) begin errors++; $display("FAIL endrop_d2: got %h want 3", digit_bin); end
    en = 1'b0;
    tick();
    checks++; if (an !== 4'hF) begin errors++; $display("FAIL endrop_dark: got %b want 1111", an); end
    checks++; if (digit_bin !== 4'h3) begin errors++; $display("FAIL endrop_hold: got %h want 3", digit_bin); end
    repeat (3) tick();
    checks++; if (an !== 4'hF) begin errors++; $display("FAIL endrop_idle_an: got %b want 1111", an); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL endrop_idle_fd: got %b want 0", frame_done); end
    en = 1'b1; ph = -1;
    tick();
    checks++; if (an !== 4'hF) begin errors++; $display("FAIL endrop_blank: got %b want 1111", an); end
    tick();
    checks++; if (an !== 4'b1110) begin errors++; $display("FAIL endrop_restart_an: got %b want 1110", an); end
    checks++; if (digit_bin !== 4'h1) begin errors++; $display("FAIL endrop_restart_d0: got %h want 1", digit_bin); end
    go_until(6);
    checks++; if (digit_bin !== 4'h2) begin errors++; $display("FAIL endrop_restart_d1: got %h want 2", digit_bin); end
  endtask

  task automatic test_rst_mid();
    test_idle_commit(16'h1234);
    en = 1'b1; ph = -1;
    go_until(3);
    load = 1'b1; value = 16'h9999;
    tick();
    load = 1'b0;
    go_until(7);
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL rstmid_pre_pending: got %b want 1", pending); end
    checks++; if (digit_bin !== 4'h3) begin errors++; $display("FAIL rstmid_pre_d1: got %h want 3", digit_bin); end
    rst = 1'b1; load = 1'b1; value = 16'hFFFF;
    tick();
    checks++; if (an !== 4'hF) begin errors++; $display("FAIL rstmid_an: got %b want 1111", an); end
    checks++; if (digit_bin !== 4'h0) begin errors++; $display("FAIL rstmid_digit: got %h want 0", digit_bin); end
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL rstmid_pending: got %b want 0", pending); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rstmid_fd: got %b want 0", frame_done); end
    rst = 1'b0; load = 1'b0; ph = -1;
    tick();
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL rstmid_load_blocked: got %b want 0", pending); end
    tick();
    checks++; if (an !== 4'b1110) begin errors++; $display("FAIL rstmid_restart_an: got %b want 1110", an); end
    checks++; if (digit_bin !== 4'h0) begin errors++; $display("FAIL rstmid_active_clr: got %h want 0", digit_bin); end
  endtask

  task automatic test_rst_boundary();
    test_idle_commit(16'h8765);
    en = 1'b1; ph = -1;
    go_until(5);
    load = 1'b1; value = 16'h1111;
    tick();
    load = 1'b0;
    go_until(19);
    checks++; if (digit_bin !== 4'h8) begin errors++; $display("FAIL rstbd_pre_d3: got %h want 8", digit_bin); end
    rst = 1'b1;
    tick();
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rstbd_fd: got %b want 0", frame_done); end
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL rstbd_pending: got %b want 0", pending); end
    checks++; if (digit_bin !== 4'h0) begin errors++; $display("FAIL rstbd_digit: got %h want 0", digit_bin); end
    rst = 1'b0; en = 1'b0;
  endtask

  task automatic test_lz();
    logic [3:0] e;
    test_idle_commit(16'h0042);
    en = 1'b1; ph = -1;
    repeat (20) begin
      tick();
      e = an_model(ph);
`ifdef DISPLAY_LZ_BLANK_EN
      if (ph % 20 >= 11) e = 4'hF;
`endif
      checks++; if (an !== e) begin errors++; $display("FAIL lz42_an[%0d]: got %b want %b", ph, an, e); end
      if (ph == 1) begin
        checks++; if (digit_bin !== 4'h2) begin errors++; $display("FAIL lz42_d0: got %h want 2", digit_bin); end
      end
      if (ph == 6) begin
        checks++; if (digit_bin !== 4'h4) begin errors++; $display("FAIL lz42_d1: got %h want 4", digit_bin); end
      end
    end
    test_idle_commit(16'h0000);
    en = 1'b1; ph = -1;
    repeat (20) begin
      tick();
      e = an_model(ph);
`ifdef DISPLAY_LZ_BLANK_EN
      if (ph % 20 >= 6) e = 4'hF;
`endif
      checks++; if (an !== e) begin errors++; $display("FAIL lz0_an[%0d]: got %b want %b", ph, an, e); end
    end
    checks++; if (digit_bin !== 4'h0) begin errors++; $display("FAIL lz0_digit: got %h want 0", digit_bin); end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load();
    test_back_to_back();
    test_en_drop();
    test_rst_mid();
    test_rst_boundary();
    test_lz();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
